encout_apb_slv: RTL and testbench
=================================

ENCOUT_APB_SLV -- requirements
Module: encout_apb_slv

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, APB address width.
REQ-002 SHALL have parameter DATA_W, default 32, APB data width.
REQ-003 SHALL have parameter N_REG, default 6, legal range 1..32, number of word registers.
REQ-004 SHALL have parameter BASE_ADDR, default 32'h0091_C100, byte address of register 0; bits [1:0] SHALL be 0.
REQ-005 SHALL have parameter WAIT_CYC, default 0, legal range 0..15, wait states inserted per access.
REQ-006 SHALL have parameter RO_MASK, N_REG bits, default 6'b10_0000; a set bit marks that register read-only.
REQ-007 SHALL have port i_clk, input, 1: the single clock; all state SHALL update on its rising edge.
REQ-008 SHALL have port i_presetn, input, 1: reset, asynchronous assert, active-low.
REQ-009 SHALL have ports i_paddr input ADDR_W, i_psel input 1, i_penable input 1, i_pwrite input 1, i_pwdata input DATA_W: APB3 request.
REQ-010 SHALL have ports o_pready output 1, o_pslverr output 1, o_prdata output DATA_W: APB3 response.
REQ-011 SHALL have ports o_we output N_REG and o_re output N_REG: one-hot register strobes.
REQ-012 SHALL have ports o_wdata output DATA_W (write data) and i_rdata input DATA_W (read data from the register block).

Function
REQ-013 SHALL implement the FSM IDLE -> ACCESS -> IDLE.
REQ-014 IDLE SHALL move to ACCESS on i_psel & ~i_penable (setup phase).
REQ-015 On setup, the block SHALL register the write flag, the hit flag and the index idx=(i_paddr-BASE_ADDR)>>2.
REQ-016 hit SHALL be 1 only when i_paddr[1:0]==0 and 0 <= idx < N_REG; a wrapped subtraction (i_paddr < BASE_ADDR) SHALL be a miss.
REQ-017 On setup, a wait counter SHALL be loaded with WAIT_CYC.
REQ-018 In ACCESS with count != 0: o_pready SHALL be 0 and the counter SHALL decrement.
REQ-019 In ACCESS with count == 0: o_pready SHALL be 1 (completion cycle) and the next state SHALL be IDLE.
REQ-020 In IDLE, o_pready SHALL be 1.
REQ-021 With WAIT_CYC=0, every transfer SHALL complete in the first access cycle (zero wait states).
REQ-022 o_pslverr SHALL be 1 only in the completion cycle, when ~hit, or when write & RO_MASK[idx].
REQ-023 o_we[idx] SHALL pulse for exactly one cycle, the completion cycle, only for a hit, non-RO write.
REQ-024 o_wdata SHALL equal i_pwdata, passed through combinationally.
REQ-025 o_re[idx] SHALL pulse for exactly one cycle, the first ACCESS cycle, only for a hit read.
REQ-026 i_rdata SHALL be valid the cycle after o_re.
REQ-027 o_prdata SHALL be registered: loaded from i_rdata in the completion cycle of a hit read, otherwise 0 for a miss read, otherwise holding its value.
REQ-028 With WAIT_CYC=0 on a read, i_rdata SHALL be sampled combinationally into the completion response (same-cycle path).
REQ-029 If i_psel falls while in ACCESS (protocol abort), the FSM SHALL return to IDLE with no o_we pulse and no o_pslverr.
REQ-030 A setup phase seen in the cycle after completion (back-to-back) SHALL start the new transfer with no idle gap.

Reset
REQ-031 On i_presetn low, state SHALL be IDLE and the counter 0.
REQ-032 During reset, o_pready SHALL be 1, o_pslverr 0, o_prdata 0, o_we 0 and o_re 0.
REQ-033 Reset asserted mid-transfer SHALL discard the transfer; no strobe SHALL be issued after reset is released.

Structure
REQ-034 Package encout_pkg SHALL hold the state enum (IDLE, ACCESS), the default BASE_ADDR and per-register offset constants (CTL, STR, POSMAX, OUTCNT, VER).
REQ-035 Sub-module encout_apb_dec (combinational address decode: hit, idx) SHALL be instantiated once.

Verification
REQ-036 The bench SHALL cover: WAIT_CYC=0, write 0x1234 to 0x91C104 -> o_we=6'b000010 for 1 cycle, o_pready=1, o_pslverr=0.
REQ-037 The bench SHALL cover: WAIT_CYC=3, read 0x91C108 with i_rdata=0xA5A5 -> 3 cycles with o_pready=0, then o_prdata=0xA5A5, o_re=6'b000100 for exactly 1 cycle.
REQ-038 The bench SHALL cover: write 0x91C114 (VER, RO) -> o_pslverr=1 at completion, o_we stays 0.
REQ-039 The bench SHALL cover: accesses to 0x91C118 (index 6), 0x91C102 (misaligned) and 0x91C0FC (below base) -> o_pslverr=1; the reads return 0.
REQ-040 The bench SHALL cover: back-to-back write then read with no idle gap -> both complete with the correct strobes.
REQ-041 The bench SHALL cover: WAIT_CYC=5, i_presetn low in the 2nd wait cycle -> outputs at reset values, no o_we pulse after reset is released.

Source files
------------

// File: rtl/encout_pkg.sv
// Shared types and constants for the encoder-output APB register slave.
// Offsets are byte offsets from BASE_ADDR_DEF.
package encout_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_e;

    localparam logic [31:0] BASE_ADDR_DEF = 32'h0091_C100;

    localparam logic [31:0] OFF_CTL    = 32'h0000_0000;
    localparam logic [31:0] OFF_STR    = 32'h0000_0004;
    localparam logic [31:0] OFF_POSMAX = 32'h0000_0008;
    localparam logic [31:0] OFF_OUTCNT = 32'h0000_000C;
    localparam logic [31:0] OFF_VER    = 32'h0000_0014;

    // Only the version register is read-only by default.
    localparam logic [5:0] RO_MASK_DEF = 6'(32'd1 << (OFF_VER >> 2));

    localparam int unsigned CNT_W = 4;

    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/encout_apb_slv_if.sv
// APB3 request/response bundle between a bus master and the encout register slave.
interface encout_apb_slv_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    logic [ADDR_W-1:0] i_paddr;
    logic              i_psel;
    logic              i_penable;
    logic              i_pwrite;
    logic [DATA_W-1:0] i_pwdata;
    logic              o_pready;
    logic              o_pslverr;
    logic [DATA_W-1:0] o_prdata;

    modport master (
        output i_paddr, i_psel, i_penable, i_pwrite, i_pwdata,
        input  o_pready, o_pslverr, o_prdata
    );

    modport slave (
        input  i_paddr, i_psel, i_penable, i_pwrite, i_pwdata,
        output o_pready, o_pslverr, o_prdata
    );
endinterface

// File: rtl/encout_apb_dec.sv
// Combinational address decode: word index relative to BASE_ADDR and a hit flag
// that rejects misaligned, out-of-range and below-base addresses.
module encout_apb_dec
    import encout_pkg::*;
#(
    parameter int unsigned       ADDR_W    = 32,
    parameter int unsigned       N_REG     = 6,
    parameter int unsigned       IDX_W     = 3,
    parameter logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(BASE_ADDR_DEF)
) (
    input  logic [ADDR_W-1:0] paddr_i,
    output logic              hit_o,
    output logic [IDX_W-1:0]  idx_o
);
    logic [ADDR_W-1:0] offset;
    logic [ADDR_W-1:0] word;
    logic              below;

    always_comb begin
        // The subtraction wraps for addresses under the base; catch that explicitly.
        below  = paddr_i < BASE_ADDR;
        offset = paddr_i - BASE_ADDR;
        word   = offset >> 2;
        hit_o  = ~below && (offset[1:0] == 2'b00) && (word < ADDR_W'(N_REG));
        idx_o  = word[IDX_W-1:0];
    end
endmodule

// File: rtl/encout_apb_slv.sv
// APB3 slave front-end for the encoder-output register block: decodes word registers,
// inserts WAIT_CYC wait states and issues one-hot read/write strobes.
module encout_apb_slv
    import encout_pkg::*;
#(
    parameter int unsigned       ADDR_W    = 32,
    parameter int unsigned       DATA_W    = 32,
    parameter int unsigned       N_REG     = 6,
    parameter logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(BASE_ADDR_DEF),
    parameter int unsigned       WAIT_CYC  = 0,
    parameter logic [N_REG-1:0]  RO_MASK   = N_REG'(RO_MASK_DEF)
) (
    input  logic              i_clk,
    input  logic              i_presetn,
    encout_apb_slv_if.slave   apb,
    output logic [N_REG-1:0]  o_we,
    output logic [N_REG-1:0]  o_re,
    output logic [DATA_W-1:0] o_wdata,
    input  logic [DATA_W-1:0] i_rdata
);
    localparam int unsigned      IDX_W   = idx_width(N_REG);
    localparam logic [CNT_W-1:0] WAIT_LD = CNT_W'(WAIT_CYC);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              write_q, hit_q;
    logic [IDX_W-1:0]  idx_q;
    logic [DATA_W-1:0] prdata_q, prdata_d;

    logic              dec_hit;
    logic [IDX_W-1:0]  dec_idx;
    logic              setup, load;

    encout_apb_dec #(
        .ADDR_W    (ADDR_W),
        .N_REG     (N_REG),
        .IDX_W     (IDX_W),
        .BASE_ADDR (BASE_ADDR)
    ) u_dec (
        .paddr_i (apb.i_paddr),
        .hit_o   (dec_hit),
        .idx_o   (dec_idx)
    );

    assign setup   = apb.i_psel & ~apb.i_penable;
    assign o_wdata = apb.i_pwdata;

    always_ff @(posedge i_clk or negedge i_presetn) begin
        if (!i_presetn) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            write_q  <= 1'b0;
            hit_q    <= 1'b0;
            idx_q    <= '0;
            prdata_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            prdata_q <= prdata_d;
            if (load) begin
                write_q <= apb.i_pwrite;
                hit_q   <= dec_hit;
                idx_q   <= dec_idx;
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        prdata_d      = prdata_q;
        load          = 1'b0;
        apb.o_pready  = 1'b1;
        apb.o_pslverr = 1'b0;
        apb.o_prdata  = prdata_q;
        o_we          = '0;
        o_re          = '0;

        case (state_q)
            IDLE: begin
                if (setup) begin
                    load    = 1'b1;
                    cnt_d   = WAIT_LD;
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                apb.o_pready = (cnt_q == '0);
                if (!apb.i_psel) begin
                    // Master abandoned the transfer: no strobes, no error.
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    // The counter still holds its load value only in the first access cycle.
                    if (cnt_q == WAIT_LD && hit_q && !write_q) begin
                        o_re[idx_q] = 1'b1;
                    end
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end else begin
                        state_d       = IDLE;
                        apb.o_pslverr = hit_q ? (write_q & RO_MASK[idx_q]) : 1'b1;
                        if (hit_q && write_q && !RO_MASK[idx_q]) begin
                            o_we[idx_q] = 1'b1;
                        end
                        if (!write_q) begin
                            // Bypass so the completion beat already carries the read data.
                            prdata_d     = hit_q ? i_rdata : '0;
                            apb.o_prdata = prdata_d;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: tb/tb_encout_apb_slv.sv
// Bench for encout_apb_slv: three instances (0, 3 and 5 wait states) share one APB driver,
// a simple register block answers the strobes, and a reference model predicts every response.
module tb_encout_apb_slv;
    import encout_pkg::*;

    localparam logic [31:0] BASE = 32'h0091_C100;

    logic        clk;
    logic        presetn;
    logic [31:0] paddr, pwdata;
    logic        psel, penable, pwrite;
    int          sel;
    int          cyc;
    int          vectors;
    int          miscompares;

    logic        pready, pslverr;
    logic [31:0] prdata, wdata, rdata;
    logic [5:0]  we, re;

    logic [5:0]  we0, we1, we2, re0, re1, re2;
    logic [31:0] wd0, wd1, wd2;

    logic [31:0] regblk [6];
    logic [31:0] exp_mem [6];
    logic [2:0]  re_idx_q;
    logic        blk_clr;

    encout_apb_slv_if #(.ADDR_W(32), .DATA_W(32)) bus0 ();
    encout_apb_slv_if #(.ADDR_W(32), .DATA_W(32)) bus1 ();
    encout_apb_slv_if #(.ADDR_W(32), .DATA_W(32)) bus2 ();

    assign bus0.i_paddr = paddr;  assign bus0.i_pwdata = pwdata;  assign bus0.i_pwrite = pwrite;
    assign bus1.i_paddr = paddr;  assign bus1.i_pwdata = pwdata;  assign bus1.i_pwrite = pwrite;
    assign bus2.i_paddr = paddr;  assign bus2.i_pwdata = pwdata;  assign bus2.i_pwrite = pwrite;
    assign bus0.i_psel = psel && (sel == 0);  assign bus0.i_penable = penable;
    assign bus1.i_psel = psel && (sel == 1);  assign bus1.i_penable = penable;
    assign bus2.i_psel = psel && (sel == 2);  assign bus2.i_penable = penable;

    encout_apb_slv #(.WAIT_CYC(0)) dut0 (
        .i_clk(clk), .i_presetn(presetn), .apb(bus0.slave),
        .o_we(we0), .o_re(re0), .o_wdata(wd0), .i_rdata(rdata)
    );
    encout_apb_slv #(.WAIT_CYC(3)) dut1 (
        .i_clk(clk), .i_presetn(presetn), .apb(bus1.slave),
        .o_we(we1), .o_re(re1), .o_wdata(wd1), .i_rdata(rdata)
    );
    encout_apb_slv #(.WAIT_CYC(5)) dut2 (
        .i_clk(clk), .i_presetn(presetn), .apb(bus2.slave),
        .o_we(we2), .o_re(re2), .o_wdata(wd2), .i_rdata(rdata)
    );

    always_comb begin
        case (sel)
            1: begin
                pready = bus1.o_pready; pslverr = bus1.o_pslverr; prdata = bus1.o_prdata;
                we = we1; re = re1; wdata = wd1;
            end
            2: begin
                pready = bus2.o_pready; pslverr = bus2.o_pslverr; prdata = bus2.o_prdata;
                we = we2; re = re2; wdata = wd2;
            end
            default: begin
                pready = bus0.o_pready; pslverr = bus0.o_pslverr; prdata = bus0.o_prdata;
                we = we0; re = re0; wdata = wd0;
            end
        endcase
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] blk_init(input int i);
        return 32'h0000_0100 + 32'(i);
    endfunction

    // Register block: stores on o_we, presents the o_re-selected word now and afterwards.
    always @(posedge clk) begin
        for (int i = 0; i < 6; i++) begin
            if (blk_clr) regblk[i] <= blk_init(i);
            else if (we[i]) regblk[i] <= wdata;
            if (re[i]) re_idx_q <= 3'(i);
        end
    end

    always_comb begin
        rdata = regblk[re_idx_q];
        for (int i = 0; i < 6; i++) if (re[i]) rdata = regblk[i];
    end

    function automatic int wait_of(input int s);
        return (s == 0) ? 0 : (s == 1) ? 3 : 5;
    endfunction

    function automatic void model(input logic [31:0] addr, input bit wr,
                                  output bit hit, output int idx, output bit err);
        longint off;
        off = longint'(addr) - longint'(BASE);
        hit = (off >= 0) && (off % 4 == 0) && (off / 4 < 6);
        idx = hit ? int'(off / 4) : 0;
        err = !hit || (wr && idx == 5);
    endfunction

    task automatic acc(inout logic [5:0] wo, inout int wt, inout logic [5:0] ro, inout int rt);
        wo |= we;
        wt += $countones(we);
        ro |= re;
        rt += $countones(re);
    endtask

    // Call just after a rising edge; returns just after a rising edge.
    task automatic do_xfer(input logic [31:0] addr, input bit wr, input logic [31:0] data,
                           input bit keep, output int waits, output bit err,
                           output logic [31:0] rd, output logic [5:0] we_or, output int we_tot,
                           output logic [5:0] re_or, output int re_tot, output bit tout,
                           output int done);
        waits = 0; err = 0; rd = '0; we_or = '0; we_tot = 0; re_or = '0; re_tot = 0;
        tout = 1; done = 0;
        psel = 1; penable = 0; paddr = addr; pwrite = wr; pwdata = data;
        @(negedge clk);
        acc(we_or, we_tot, re_or, re_tot);
        @(posedge clk); #1;
        penable = 1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            acc(we_or, we_tot, re_or, re_tot);
            if (pready) begin
                err = pslverr; rd = prdata; tout = 0; done = cyc;
                break;
            end
            waits++;
        end
        @(posedge clk); #1;
        if (!keep) begin
            psel = 0; penable = 0;
            @(negedge clk);
            acc(we_or, we_tot, re_or, re_tot);
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        presetn = 0; blk_clr = 1; psel = 0; penable = 0; pwrite = 0;
        paddr = '0; pwdata = '0; sel = 0;
        repeat (3) @(posedge clk);
        for (int s = 0; s < 3; s++) begin
            sel = s; #1;
            vectors += 5;
            if (pready !== 1'b1) begin miscompares++; $display("FAIL rst_pready[%0d]: got %b want 1", s, pready); end
            if (pslverr !== 1'b0) begin miscompares++; $display("FAIL rst_pslverr[%0d]: got %b want 0", s, pslverr); end
            if (prdata !== 32'h0) begin miscompares++; $display("FAIL rst_prdata[%0d]: got %h want 0", s, prdata); end
            if (we !== 6'h0) begin miscompares++; $display("FAIL rst_we[%0d]: got %b want 0", s, we); end
            if (re !== 6'h0) begin miscompares++; $display("FAIL rst_re[%0d]: got %b want 0", s, re); end
        end
        for (int i = 0; i < 6; i++) exp_mem[i] = blk_init(i);
        sel = 0;
        @(posedge clk); #1;
        presetn = 1; blk_clr = 0;
        @(posedge clk); #1;
    endtask

    task automatic test_write_w0();
        int w, wt, rt, d; bit e, t; logic [31:0] r; logic [5:0] wo, ro;
        sel = 0;
        do_xfer(BASE + 32'h4, 1, 32'h1234, 0, w, e, r, wo, wt, ro, rt, t, d);
        exp_mem[1] = 32'h1234;
        vectors += 6;
        if (t !== 1'b0) begin miscompares++; $display("FAIL w0_timeout: got %b want 0", t); end
        if (w !== 0) begin miscompares++; $display("FAIL w0_waits: got %0d want 0", w); end
        if (e !== 1'b0) begin miscompares++; $display("FAIL w0_pslverr: got %b want 0", e); end
        if (wo !== 6'b000010) begin miscompares++; $display("FAIL w0_we: got %b want 000010", wo); end
        if (wt !== 1) begin miscompares++; $display("FAIL w0_we_cycles: got %0d want 1", wt); end
        if (regblk[1] !== exp_mem[1]) begin miscompares++; $display("FAIL w0_wdata: got %h want %h", regblk[1], exp_mem[1]); end
    endtask

    task automatic test_read_w3();
        int w, wt, rt, d; bit e, t; logic [31:0] r; logic [5:0] wo, ro;
        sel = 0;
        do_xfer(BASE + 32'h8, 1, 32'hA5A5, 0, w, e, r, wo, wt, ro, rt, t, d);
        exp_mem[2] = 32'hA5A5;
        sel = 1;
        do_xfer(BASE + 32'h8, 0, 32'h0, 0, w, e, r, wo, wt, ro, rt, t, d);
        @(negedge clk);
        vectors += 7;
        if (w !== 3) begin miscompares++; $display("FAIL w3_waits: got %0d want 3", w); end
        if (e !== 1'b0) begin miscompares++; $display("FAIL w3_pslverr: got %b want 0", e); end
        if (r !== 32'hA5A5) begin miscompares++; $display("FAIL w3_prdata: got %h want a5a5", r); end
        if (ro !== 6'b000100) begin miscompares++; $display("FAIL w3_re: got %b want 000100", ro); end
        if (rt !== 1) begin miscompares++; $display("FAIL w3_re_cycles: got %0d want 1", rt); end
        if (wt !== 0) begin miscompares++; $display("FAIL w3_we_cycles: got %0d want 0", wt); end
        if (prdata !== 32'hA5A5) begin miscompares++; $display("FAIL w3_prdata_hold: got %h want a5a5", prdata); end
        @(posedge clk); #1;
    endtask

    task automatic test_read_only();
        int w, wt, rt, d; bit e, t; logic [31:0] r; logic [5:0] wo, ro;
        sel = 0;
        do_xfer(BASE + 32'h14, 1, 32'hDEAD_BEEF, 0, w, e, r, wo, wt, ro, rt, t, d);
        vectors += 2;
        if (e !== 1'b1) begin miscompares++; $display("FAIL ro_pslverr: got %b want 1", e); end
        if (wt !== 0) begin miscompares++; $display("FAIL ro_we_cycles: got %0d want 0", wt); end
        do_xfer(BASE + 32'h14, 0, 32'h0, 0, w, e, r, wo, wt, ro, rt, t, d);
        vectors += 2;
        if (e !== 1'b0) begin miscompares++; $display("FAIL ro_read_err: got %b want 0", e); end
        if (r !== exp_mem[5]) begin miscompares++; $display("FAIL ro_read_data: got %h want %h", r, exp_mem[5]); end
    endtask

    task automatic test_miss();
        int w, wt, rt, d; bit e, t; logic [31:0] r; logic [5:0] wo, ro;
        logic [31:0] addrs [3];
        addrs[0] = BASE + 32'h18; addrs[1] = BASE + 32'h2; addrs[2] = BASE - 32'h4;
        for (int s = 0; s < 2; s++) begin
            sel = s;
            for (int a = 0; a < 3; a++) begin
                do_xfer(addrs[a], 0, 32'h0, 0, w, e, r, wo, wt, ro, rt, t, d);
                vectors += 3;
                if (e !== 1'b1) begin miscompares++; $display("FAIL miss_rd_err[%0d,%0d]: got %b want 1", s, a, e); end
                if (r !== 32'h0) begin miscompares++; $display("FAIL miss_rd_data[%0d,%0d]: got %h want 0", s, a, r); end
                if (rt !== 0) begin miscompares++; $display("FAIL miss_re[%0d,%0d]: got %0d want 0", s, a, rt); end
                do_xfer(addrs[a], 1, 32'hFFFF_FFFF, 0, w, e, r, wo, wt, ro, rt, t, d);
                vectors += 2;
                if (e !== 1'b1) begin miscompares++; $display("FAIL miss_wr_err[%0d,%0d]: got %b want 1", s, a, e); end
                if (wt !== 0) begin miscompares++; $display("FAIL miss_we[%0d,%0d]: got %0d want 0", s, a, wt); end
                // A hit read restores non-zero prdata so the next miss read is meaningful.
                do_xfer(BASE + 32'h14, 0, 32'h0, 0, w, e, r, wo, wt, ro, rt, t, d);
            end
        end
    endtask

    task automatic test_back_to_back();
        int w, wt, rt, d1, d2, i; bit e, t; logic [31:0] r, v; logic [5:0] wo, ro;
        for (int s = 0; s < 2; s++) begin
            sel = s; v = $urandom; i = $urandom_range(0, 4);
            do_xfer(BASE + 32'(4 * i), 1, v, 1, w, e, r, wo, wt, ro, rt, t, d1);
            exp_mem[i] = v;
            vectors += 2;
            if (wo !== 6'(1 << i)) begin miscompares++; $display("FAIL b2b_we[%0d]: got %b want %b", s, wo, 6'(1 << i)); end
            if (wt !== 1) begin miscompares++; $display("FAIL b2b_we_cycles[%0d]: got %0d want 1", s, wt); end
            do_xfer(BASE + 32'(4 * i), 0, 32'h0, 0, w, e, r, wo, wt, ro, rt, t, d2);
            vectors += 4;
            if (r !== exp_mem[i]) begin miscompares++; $display("FAIL b2b_rdata[%0d]: got %h want %h", s, r, exp_mem[i]); end
            if (ro !== 6'(1 << i)) begin miscompares++; $display("FAIL b2b_re[%0d]: got %b want %b", s, ro, 6'(1 << i)); end
            if (e !== 1'b0) begin miscompares++; $display("FAIL b2b_err[%0d]: got %b want 0", s, e); end
            if (d2 - d1 !== wait_of(s) + 2) begin miscompares++; $display("FAIL b2b_gap[%0d]: got %0d want %0d", s, d2 - d1, wait_of(s) + 2); end
        end
    endtask

    task automatic test_abort();
        int w, wt, rt, d, errs; bit e, t; logic [31:0] r; logic [5:0] wo, ro;
        sel = 1; wo = '0; wt = 0; ro = '0; rt = 0; errs = 0;
        psel = 1; penable = 0; paddr = BASE; pwrite = 1; pwdata = 32'h0BAD_0BAD;
        @(posedge clk); #1;
        penable = 1;
        @(negedge clk);
        vectors++;
        if (pready !== 1'b0) begin miscompares++; $display("FAIL abort_wait: got %b want 0", pready); end
        @(posedge clk); #1;
        psel = 0; penable = 0;
        repeat (6) begin
            @(negedge clk);
            acc(wo, wt, ro, rt);
            if (pslverr) errs++;
        end
        vectors += 3;
        if (wt !== 0) begin miscompares++; $display("FAIL abort_we: got %0d want 0", wt); end
        if (errs !== 0) begin miscompares++; $display("FAIL abort_pslverr: got %0d want 0", errs); end
        if (pready !== 1'b1) begin miscompares++; $display("FAIL abort_idle: got %b want 1", pready); end
        @(posedge clk); #1;
        do_xfer(BASE, 0, 32'h0, 0, w, e, r, wo, wt, ro, rt, t, d);
        vectors++;
        if (r !== exp_mem[0]) begin miscompares++; $display("FAIL abort_after: got %h want %h", r, exp_mem[0]); end
    endtask

    task automatic test_reset_mid();
        int w, wt, rt, d; bit e, t; logic [31:0] r; logic [5:0] wo, ro;
        sel = 2;
        do_xfer(BASE + 32'h8, 0, 32'h0, 0, w, e, r, wo, wt, ro, rt, t, d);
        vectors += 2;
        if (w !== 5) begin miscompares++; $display("FAIL w5_waits: got %0d want 5", w); end
        if (r !== exp_mem[2]) begin miscompares++; $display("FAIL w5_rdata: got %h want %h", r, exp_mem[2]); end
        psel = 1; penable = 0; paddr = BASE + 32'hC; pwrite = 1; pwdata = 32'h7777_7777;
        @(posedge clk); #1;
        penable = 1;
        @(posedge clk); #1;
        presetn = 0;
        @(negedge clk);
        vectors += 5;
        if (pready !== 1'b1) begin miscompares++; $display("FAIL mid_pready: got %b want 1", pready); end
        if (pslverr !== 1'b0) begin miscompares++; $display("FAIL mid_pslverr: got %b want 0", pslverr); end
        if (prdata !== 32'h0) begin miscompares++; $display("FAIL mid_prdata: got %h want 0", prdata); end
        if (we !== 6'h0) begin miscompares++; $display("FAIL mid_we: got %b want 0", we); end
        if (re !== 6'h0) begin miscompares++; $display("FAIL mid_re: got %b want 0", re); end
        @(posedge clk); #1;
        presetn = 1; psel = 0; penable = 0;
        wo = '0; wt = 0; ro = '0; rt = 0;
        repeat (10) begin
            @(negedge clk);
            acc(wo, wt, ro, rt);
        end
        vectors += 2;
        if (wt !== 0) begin miscompares++; $display("FAIL mid_we_after: got %0d want 0", wt); end
        if (regblk[3] !== exp_mem[3]) begin miscompares++; $display("FAIL mid_reg: got %h want %h", regblk[3], exp_mem[3]); end
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        int w, wt, rt, d, idx, kind; bit e, t, hit, xerr, wr; logic [31:0] r, addr, v;
        logic [5:0] wo, ro, xwe, xre;
        for (int n = 0; n < 30; n++) begin
            sel = $urandom_range(0, 2);
            kind = $urandom_range(0, 9);
            if (kind < 7) addr = BASE + 32'(4 * $urandom_range(0, 5));
            else if (kind == 7) addr = BASE + 32'(4 * $urandom_range(6, 9));
            else if (kind == 8) addr = BASE + 32'($urandom_range(1, 3) + 4 * $urandom_range(0, 5));
            else addr = BASE - 32'(4 * $urandom_range(1, 4));
            wr = 1'($urandom_range(0, 1));
            v = $urandom;
            model(addr, wr, hit, idx, xerr);
            xwe = (hit && wr && !xerr) ? 6'(1 << idx) : 6'h0;
            xre = (hit && !wr) ? 6'(1 << idx) : 6'h0;
            do_xfer(addr, wr, v, 0, w, e, r, wo, wt, ro, rt, t, d);
            vectors += 6;
            if (t !== 1'b0) begin miscompares++; $display("FAIL rnd_timeout[%0d]: got %b want 0", n, t); end
            if (w !== wait_of(sel)) begin miscompares++; $display("FAIL rnd_waits[%0d]: got %0d want %0d", n, w, wait_of(sel)); end
            if (e !== xerr) begin miscompares++; $display("FAIL rnd_err[%0d] addr %h: got %b want %b", n, addr, e, xerr); end
            if (wo !== xwe || wt !== $countones(xwe)) begin
                miscompares++; $display("FAIL rnd_we[%0d] addr %h: got %b/%0d want %b", n, addr, wo, wt, xwe);
            end
            if (ro !== xre || rt !== $countones(xre)) begin
                miscompares++; $display("FAIL rnd_re[%0d] addr %h: got %b/%0d want %b", n, addr, ro, rt, xre);
            end
            if (!wr && r !== (hit ? exp_mem[idx] : 32'h0)) begin
                miscompares++; $display("FAIL rnd_rdata[%0d] addr %h: got %h want %h", n, addr, r, hit ? exp_mem[idx] : 32'h0);
            end
            if (xwe != 6'h0) exp_mem[idx] = v;
        end
        for (int i = 0; i < 6; i++) begin
            vectors++;
            if (regblk[i] !== exp_mem[i]) begin miscompares++; $display("FAIL final_reg[%0d]: got %h want %h", i, regblk[i], exp_mem[i]); end
        end
    endtask

    initial begin
        vectors = 0; miscompares = 0; cyc = 0;
        test_reset();
        test_write_w0();
        test_read_w3();
        test_read_only();
        test_miss();
        test_back_to_back();
        test_abort();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
